fifo_axis_arb: RTL and testbench

Round-robin AXI-Stream arbiter that shares the single slave port of `fifo_axis` between `NUM_SRC` producers. Each producer gets a grant for a burst of up to `MAX_BURST` beats, and the grant then rotates. The master side connects directly to `fifo_axis` `s_tvalid`/`s_tready`/`s_tdata`. The block holds no data storage: the datapath is a registered-select multiplexer.

---
 rtl/fifo_axis_arb_pkg.sv | 14 +
 rtl/fifo_axis_arb_pick.sv | 27 ++
 rtl/fifo_axis_arb.sv | 102 ++++++++++
 tb/tb_fifo_axis_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_arb_pkg.sv
// Shared types and helpers for the fifo_axis round-robin arbiter.
package fifo_axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index + 1 with explicit wrap, so non-power-of-two source counts work.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_axis_arb_pick.sv
// Round-robin priority pick: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int unsigned cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!any && |(req & (N'(1) << cand))) begin
        any = 1'b1;
        idx = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_axis_arb.sv
// Round-robin AXI-Stream arbiter feeding the fifo_axis slave port; bursts of up to MAX_BURST beats.
// Optional m_tid output enabled by defining FIFO_AXIS_ARB_TID_EN.
module fifo_axis_arb
  import fifo_axis_arb_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic [NUM_SRC*DATAWIDTH-1:0]  s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATAWIDTH-1:0]          m_tdata
`ifdef FIFO_AXIS_ARB_TID_EN
  ,
  output logic [ID_WIDTH-1:0]           m_tid
`endif
);

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  ptr_q,   ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 pick_any;
  logic                 sel_valid;
  logic [DATAWIDTH-1:0] sel_data;
  logic                 beat;

  rr_priority_pick #(
    .N   (NUM_SRC),
    .IDW (ID_WIDTH)
  ) u_pick (
    .req (s_tvalid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_valid = |(s_tvalid & (NUM_SRC'(1) << grant_q));
    sel_data  = DATAWIDTH'(s_tdata >> (32'(grant_q) * DATAWIDTH));
    beat      = (state_q == ARB_GRANT) && sel_valid && m_tready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        m_tvalid = sel_valid;
        m_tdata  = sel_valid ? sel_data : '0;
        s_tready = NUM_SRC'(m_tready) << grant_q;
        if (beat) cnt_d = cnt_q + 1'b1;
        // Stalled beats (m_tready low) never release; only completed beats count.
        if ((beat && cnt_q == CNT_WIDTH'(MAX_BURST - 1)) || !sel_valid) begin
          state_d = ARB_IDLE;
          ptr_d   = ID_WIDTH'(rr_next(32'(grant_q), NUM_SRC));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef FIFO_AXIS_ARB_TID_EN
  always_comb m_tid = (state_q == ARB_GRANT) ? grant_q : '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_arb.sv
// Directed bench for fifo_axis_arb: vector table plus burst, round-robin, backpressure and reset sequences.
module tb_fifo_axis_arb;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
`ifdef FIFO_AXIS_ARB_TID_EN
  logic [IW-1:0]    m_tid;
`endif

  fifo_axis_arb #(
    .DATAWIDTH (DW),
    .NUM_SRC   (NS),
    .ID_WIDTH  (IW),
    .MAX_BURST (MB),
    .CNT_WIDTH (CW)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata)
`ifdef FIFO_AXIS_ARB_TID_EN
    ,
    .m_tid    (m_tid)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] tv;
    logic       rdy;
    logic       mv;
    logic [3:0] sr;
    logic [7:0] md;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NS-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < int'(NS); i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] outl[$];
    logic [7:0] exp_out[10];
    int runs[$];
    int run, gap, got, beats, idx, cnt0, cnt1;
    logic bt;

    // Reset held with every producer requesting
    rstn     = 1'b0;
    s_tvalid = '1;
    s_tdata  = 32'hD3C2B1A0;
    m_tready = 1'b1;
    #2;
    for (int c = 0; c < 3; c++) begin
      chk("rst_mvalid", 32'(m_tvalid), 32'd0);
      chk("rst_sready", 32'(s_tready), 32'd0);
      chk("rst_mdata",  32'(m_tdata),  32'd0);
      tick();
    end

    // Vector table: starts in IDLE with ptr=0; producer i data = {D3,C2,B1,A0}
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00};
    vecs[1]  = '{4'b0110, 1'b1, 1'b0, 4'b0000, 8'h00};
    vecs[2]  = '{4'b0110, 1'b1, 1'b1, 4'b0010, 8'hB1};
    vecs[3]  = '{4'b0110, 1'b0, 1'b1, 4'b0000, 8'hB1};
    vecs[4]  = '{4'b0100, 1'b1, 1'b0, 4'b0010, 8'h00};
    vecs[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 8'h00};
    vecs[6]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 8'hC2};
    vecs[7]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 8'hC2};
    vecs[8]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 8'hC2};
    vecs[9]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 8'hC2};
    vecs[10] = '{4'b1001, 1'b1, 1'b0, 4'b0000, 8'h00};
    vecs[11] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 8'hD3};
    vecs[12] = '{4'b0001, 1'b1, 1'b0, 4'b1000, 8'h00};
    vecs[13] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 8'h00};
    vecs[14] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 8'hA0};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 8'h00};
    vecs[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00};

    do_reset();
    s_tdata = 32'hD3C2B1A0;
    foreach (vecs[i]) begin
      s_tvalid = vecs[i].tv;
      m_tready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_mvalid", i), 32'(m_tvalid), 32'(vecs[i].mv));
      chk($sformatf("vec%0d_sready", i), 32'(s_tready), 32'(vecs[i].sr));
      chk($sformatf("vec%0d_mdata", i),  32'(m_tdata),  32'(vecs[i].md));
      tick();
    end

    // Single source: producer 2 streams 0..9, expect bursts 4/4/2 with 1-cycle gaps
    do_reset();
    got = 0; run = 0; gap = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      s_tvalid = (got < 10) ? 4'b0100 : 4'b0000;
      s_tdata  = '0;
      s_tdata[2*DW +: DW] = 8'(got);
      #1;
      bt = m_tvalid && s_tready[2];
      if (bt) begin
        chk("single_data", 32'(m_tdata), 32'(got));
        if (run == 0 && runs.size() > 0) chk("single_gap", 32'(gap), 32'd1);
        run++;
        gap = 0;
      end else begin
        if (run > 0) begin runs.push_back(run); run = 0; end
        gap++;
      end
      tick();
      if (bt) got++;
    end
    if (run > 0) runs.push_back(run);
    chk("single_total", 32'(got), 32'd10);
    chk("single_nruns", 32'(runs.size()), 32'd3);
    if (runs.size() == 3) begin
      chk("single_run0", 32'(runs[0]), 32'd4);
      chk("single_run1", 32'(runs[1]), 32'd4);
      chk("single_run2", 32'(runs[2]), 32'd2);
    end

    // Round robin: all valid, 25 cycles = 5 grants of 4 beats + 1 idle each
    do_reset();
    s_tvalid = 4'b1111;
    s_tdata  = 32'h33323130;
    m_tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (m_tvalid) begin
        idx = onehot_idx(s_tready);
        chk("rr_onehot", 32'($onehot(s_tready)), 32'd1);
        chk("rr_src", 32'(idx), 32'((beats / 4) % 4));
        chk("rr_data", 32'(m_tdata), 32'(8'h30 + 8'((beats / 4) % 4)));
`ifdef FIFO_AXIS_ARB_TID_EN
        chk("rr_tid", 32'(m_tid), 32'((beats / 4) % 4));
`endif
        beats++;
      end
      tick();
    end
    chk("rr_beats", 32'(beats), 32'd20);

    // Backpressure: downstream FIFO depth 4 prefilled with 2 entries, reader idle until cycle 10
    do_reset();
    q.delete(); outl.delete();
    q.push_back(8'hEE); q.push_back(8'hEF);
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 60; c++) begin
      s_tvalid = {2'b00, cnt1 < 4, cnt0 < 4};
      s_tdata  = {16'h0000, 8'(8'h10 + cnt1), 8'(cnt0)};
      m_tready = (q.size() < 4);
      #1;
      if (c >= 3 && c < 10) begin
        chk("bp_sready", 32'(s_tready), 32'd0);
        chk("bp_mvalid", 32'(m_tvalid), 32'd1);
        chk("bp_mdata",  32'(m_tdata),  32'h02);
      end
      bt  = m_tvalid && m_tready;
      idx = onehot_idx(s_tready);
      if (bt) q.push_back(m_tdata);
      tick();
      if (bt && idx == 0) cnt0++;
      if (bt && idx == 1) cnt1++;
      if (c >= 10 && q.size() > 0) outl.push_back(q.pop_front());
    end
    exp_out = '{8'hEE, 8'hEF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
    chk("bp_count", 32'(outl.size()), 32'd10);
    if (outl.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("bp_out%0d", i), 32'(outl[i]), 32'(exp_out[i]));

    // Early release after 2 beats, then reset mid-burst
    do_reset();
    s_tvalid = 4'b0110;
    s_tdata  = 32'h00625140;
    m_tready = 1'b1;
    #1; chk("er_idle", 32'(m_tvalid), 32'd0); tick();
    chk("er_beat1", 32'(s_tready), 32'b0010); tick();
    chk("er_beat2", 32'(s_tready), 32'b0010); tick();
    s_tvalid = 4'b0100;
    #1; chk("er_release", 32'(m_tvalid), 32'd0); tick();
    chk("er_idle2", 32'(s_tready), 32'd0); tick();
    chk("er_grant2", 32'(s_tready), 32'b0100);
    chk("er_data2", 32'(m_tdata), 32'h62); tick();
    chk("er_mid", 32'(s_tready), 32'b0100);
    #2;
    rstn = 1'b0;
    #1;
    chk("er_rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("er_rst_sready", 32'(s_tready), 32'd0);
    chk("er_rst_mdata",  32'(m_tdata),  32'd0);
    s_tvalid = 4'b0101;
    tick(); tick();
    rstn = 1'b1;
    #1; chk("er_post_idle", 32'(m_tvalid), 32'd0); tick();
    chk("er_post_grant", 32'(s_tready), 32'b0001);
    chk("er_post_data", 32'(m_tdata), 32'h40);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
